lcd_bus_reader: RTL

- Read-side engine for the HD44780-compatible character LCD 8-bit bus. The existing LCD controller only writes to this bus.
- Performs timed read cycles with RW=1:
  - RS=0 reads the busy flag and address counter.
  - RS=1 reads DDRAM/CGRAM data.
- Optional poll mode repeats busy-flag reads until BF=0 or a timeout expires.
- Sits beside the LCD writer at top level. oBusOwn selects which block drives LCD_RW/LCD_EN/LCD_RS.

---
 rtl/lcd_bus_reader.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_reader.sv
// ----------------------------------------------------------------------------
// lcd_bus_reader
//
// Read-side engine for an HD44780-compatible character LCD on an 8-bit bus.
// It runs timed read cycles with RW=1. RS=0 returns the busy flag and the
// address counter. RS=1 returns DDRAM/CGRAM data.
//
// In poll mode the block keeps reading the busy flag until BF (bit 7) is 0,
// or until POLL_MAX reads have been done. The LCD writer lives beside this
// block. oBusOwn tells the top level which block drives the LCD control pins.
//
// Ports:
//   iCLK      in   1  system clock (50 MHz nominal)
//   iRST_N    in   1  asynchronous active-low reset
//   iStart    in   1  command request, sampled only when idle
//   iRS       in   1  register select for the command (0 = BF/AC, 1 = data)
//   iPoll     in   1  repeat BF/AC reads until BF=0 (ignored when iRS=1)
//   oBusy     out  1  engine is not idle
//   oBusOwn   out  1  this block owns LCD_RW/LCD_EN/LCD_RS
//   oDone     out  1  one-cycle completion pulse
//   oData     out  8  last captured byte, held until the next accepted start
//   oTimeout  out  1  poll ended with BF still set
//   LCD_DATA  io   8  LCD data bus (never driven here, input path only)
//   LCD_RW    out  1  LCD read/write line
//   LCD_EN    out  1  LCD enable strobe
//   LCD_RS    out  1  LCD register select line
//
// Every output comes straight from a flop. Each output register is loaded
// from a decode of the next state, so the pins change on the same edge as
// the state register. The asynchronous reset clears LCD_EN at once, without
// waiting for a clock edge.
// ----------------------------------------------------------------------------
module lcd_bus_reader #(
    parameter int SETUP_CYC   = 8,
    parameter int EN_HIGH_CYC = 25,
    parameter int SAMPLE_CYC  = 20,
    parameter int EN_LOW_CYC  = 25,
    parameter int POLL_MAX    = 65535
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    output logic       oBusy,
    output logic       oBusOwn,
    output logic       oDone,
    output logic [7:0] oData,
    output logic       oTimeout,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    // ------------------------------------------------------------------------
    // Counter sizing. One phase counter is shared by SETUP, EN_HIGH, HOLD and
    // RECOVER, so it must hold the largest phase length. The poll counter
    // counts from 0 to POLL_MAX-1 and never has to go past that value.
    // ------------------------------------------------------------------------
    localparam int PHASE_MAX_A = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int PHASE_MAX   = (PHASE_MAX_A > EN_LOW_CYC) ? PHASE_MAX_A : EN_LOW_CYC;
    localparam int CNT_W       = (PHASE_MAX > 2) ? $clog2(PHASE_MAX + 1) : 2;
    localparam int POLL_W      = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    localparam logic [CNT_W-1:0]  SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  EN_LAST     = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_IDX  = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  RECOV_LAST  = CNT_W'(EN_LOW_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(0);
    localparam logic [POLL_W-1:0] POLL_LAST   = POLL_W'(POLL_MAX - 1);
    localparam logic [POLL_W-1:0] POLL_ONE    = POLL_W'(1);
    localparam logic [POLL_W-1:0] POLL_ZERO   = POLL_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EN_HIGH = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // The data bus is read-only for this block.
    assign LCD_DATA = 8'hzz;

    state_t              state_r;
    state_t              next_state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_next_s;
    logic [POLL_W-1:0]   poll_cnt_r;
    logic [POLL_W-1:0]   poll_cnt_next_s;
    logic                rs_r;
    logic                rs_next_s;
    logic                poll_r;
    logic                poll_next_s;
    logic [7:0]          capture_r;
    logic                capture_en_s;
    logic                accept_s;
    logic                timeout_set_s;

    logic                lcd_rw_r;
    logic                lcd_en_r;
    logic                lcd_rs_r;
    logic                busy_r;
    logic                bus_own_r;
    logic                done_r;
    logic [7:0]          data_r;
    logic                timeout_r;

    logic                lcd_rw_next_s;
    logic                lcd_en_next_s;
    logic                lcd_rs_next_s;
    logic                busy_next_s;
    logic                bus_own_next_s;
    logic                done_next_s;
    logic [7:0]          data_next_s;
    logic                timeout_next_s;

    // Next-state logic, phase and poll counters, and command latching.
    always_comb begin
        next_state_s    = state_r;
        cnt_next_s      = cnt_r;
        poll_cnt_next_s = poll_cnt_r;
        rs_next_s       = rs_r;
        poll_next_s     = poll_r;
        capture_en_s    = 1'b0;
        accept_s        = 1'b0;
        timeout_set_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (iStart) begin
                    accept_s        = 1'b1;
                    rs_next_s       = iRS;
                    // Polling only makes sense on the busy-flag register.
                    poll_next_s     = iPoll & ~iRS;
                    poll_cnt_next_s = POLL_ZERO;
                    cnt_next_s      = CNT_ZERO;
                    next_state_s    = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    cnt_next_s   = CNT_ZERO;
                    next_state_s = ST_EN_HIGH;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end

            ST_EN_HIGH: begin
                // cnt_r is the 0-based EN-high cycle index.
                capture_en_s = (cnt_r == SAMPLE_IDX);
                if (cnt_r == EN_LAST) begin
                    cnt_next_s   = CNT_ZERO;
                    next_state_s = ST_HOLD;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    cnt_next_s   = CNT_ZERO;
                    next_state_s = ST_RECOVER;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end

            ST_RECOVER: begin
                if (cnt_r == RECOV_LAST) begin
                    cnt_next_s = CNT_ZERO;
                    if (poll_r && capture_r[7]) begin
                        // The compare against POLL_LAST keeps the poll count
                        // from ever wrapping.
                        if (poll_cnt_r < POLL_LAST) begin
                            poll_cnt_next_s = poll_cnt_r + POLL_ONE;
                            next_state_s    = ST_SETUP;
                        end else begin
                            timeout_set_s = 1'b1;
                            next_state_s  = ST_DONE;
                        end
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end

            ST_DONE: begin
                next_state_s = ST_IDLE;
            end

            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Decode of the next state into the next values of the output registers.
    always_comb begin
        lcd_rw_next_s  = 1'b0;
        lcd_en_next_s  = 1'b0;
        lcd_rs_next_s  = 1'b0;
        busy_next_s    = 1'b1;
        bus_own_next_s = 1'b0;
        done_next_s    = 1'b0;
        data_next_s    = data_r;
        timeout_next_s = timeout_r;

        case (next_state_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
            end
            ST_SETUP, ST_HOLD: begin
                lcd_rw_next_s  = 1'b1;
                lcd_rs_next_s  = rs_next_s;
                bus_own_next_s = 1'b1;
            end
            ST_EN_HIGH: begin
                lcd_rw_next_s  = 1'b1;
                lcd_en_next_s  = 1'b1;
                lcd_rs_next_s  = rs_next_s;
                bus_own_next_s = 1'b1;
            end
            ST_RECOVER: begin
                bus_own_next_s = 1'b1;
            end
            ST_DONE: begin
                done_next_s = 1'b1;
                data_next_s = capture_r;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase

        if (accept_s) begin
            timeout_next_s = 1'b0;
        end else if (timeout_set_s) begin
            timeout_next_s = 1'b1;
        end else begin
            timeout_next_s = timeout_r;
        end
    end

    // State, counters, latched command and data capture register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            poll_cnt_r <= POLL_ZERO;
            rs_r       <= 1'b0;
            poll_r     <= 1'b0;
            capture_r  <= 8'h00;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= cnt_next_s;
            poll_cnt_r <= poll_cnt_next_s;
            rs_r       <= rs_next_s;
            poll_r     <= poll_next_s;
            if (capture_en_s) begin
                capture_r <= LCD_DATA;
            end
        end
    end

    // Output registers, so the pins are glitch-free and reset at once.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            lcd_rw_r  <= 1'b0;
            lcd_en_r  <= 1'b0;
            lcd_rs_r  <= 1'b0;
            busy_r    <= 1'b0;
            bus_own_r <= 1'b0;
            done_r    <= 1'b0;
            data_r    <= 8'h00;
            timeout_r <= 1'b0;
        end else begin
            lcd_rw_r  <= lcd_rw_next_s;
            lcd_en_r  <= lcd_en_next_s;
            lcd_rs_r  <= lcd_rs_next_s;
            busy_r    <= busy_next_s;
            bus_own_r <= bus_own_next_s;
            done_r    <= done_next_s;
            data_r    <= data_next_s;
            timeout_r <= timeout_next_s;
        end
    end

    assign LCD_RW   = lcd_rw_r;
    assign LCD_EN   = lcd_en_r;
    assign LCD_RS   = lcd_rs_r;
    assign oBusy    = busy_r;
    assign oBusOwn  = bus_own_r;
    assign oDone    = done_r;
    assign oData    = data_r;
    assign oTimeout = timeout_r;

endmodule
